// File: rtl/pc_call_stack.sv
// Program counter with a hardware return-address stack.
// Commands (one per cycle, priority jsr > ret > jmp > preload > increment)
// update pc, the stack and the sticky error flags on the rising clock edge.
module pc_call_stack #(
  parameter  int ADDR_W = 11,
  parameter  int REL_W  = 10,
  parameter  int DEPTH  = 4,
  localparam int SP_W   = $clog2(DEPTH + 1)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              preload_i,
  input  logic [ADDR_W-1:0] preload_addr_i,
  input  logic [REL_W-1:0]  relative_addr_i,
  input  logic              jsr_i,
  input  logic              ret_i,
  input  logic              jmp_i,
  input  logic              clear_err_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] incr_pc_o,
  output logic [SP_W-1:0]   sp_o,
  output logic [ADDR_W-1:0] stack_top_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  logic [ADDR_W-1:0]             pc_q, pc_d;
  logic [ADDR_W-1:0]             incr_pc_q, incr_pc_d;
  logic [SP_W-1:0]               sp_q, sp_d;
  logic [ADDR_W-1:0]             top_q, top_d;
  logic [DEPTH-1:0][ADDR_W-1:0]  stack_q, stack_d;
  logic                          ovf_q, ovf_d;
  logic                          unf_q, unf_d;
  logic                          full, empty;
  logic                          push;
  logic                          ovf_set, unf_set;
  logic [ADDR_W-1:0]             off;

  assign full  = (sp_q == SP_W'(DEPTH));
  assign empty = (sp_q == '0);
  assign off   = {{(ADDR_W-REL_W){relative_addr_i[REL_W-1]}}, relative_addr_i};

  // Next pc / sp selection; wrap-around of all sums is intentional and silent.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (enable_i) begin
      if (jsr_i) begin
        if (!full) begin
          push = 1'b1;
          sp_d = sp_q + SP_W'(1);
          pc_d = pc_q + off + ADDR_W'(1);
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
          ovf_set = 1'b1;
        end
      end else if (ret_i) begin
        if (!empty) begin
          // top_q always mirrors stack[sp-1], so no indexed read is needed here
          pc_d = top_q + ADDR_W'(1);
          sp_d = sp_q - SP_W'(1);
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
          unf_set = 1'b1;
        end
      end else if (jmp_i) begin
        pc_d = pc_q + off + ADDR_W'(1);
      end else if (preload_i) begin
        pc_d = preload_addr_i;
      end else begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end
  end

  // Stack write on push; popped entries are left in place.
  always_comb begin
    stack_d = stack_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (push && sp_q == SP_W'(i)) stack_d[i] = pc_q;
    end
  end

  // Registered view of the entry below the post-update stack pointer.
  always_comb begin
    top_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_d == SP_W'(i + 1)) top_d = stack_d[i];
    end
  end

  // Sticky flags: a new error beats clear_err; clear_err works even when stalled.
  always_comb begin
    incr_pc_d = pc_d + ADDR_W'(1);
    ovf_d     = ovf_set | (ovf_q & ~clear_err_i);
    unf_d     = unf_set | (unf_q & ~clear_err_i);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pc_q      <= '0;
      incr_pc_q <= ADDR_W'(1);
      sp_q      <= '0;
      top_q     <= '0;
      stack_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      incr_pc_q <= incr_pc_d;
      sp_q      <= sp_d;
      top_q     <= top_d;
      stack_q   <= stack_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign pc_o        = pc_q;
  assign incr_pc_o   = incr_pc_q;
  assign sp_o        = sp_q;
  assign stack_top_o = top_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Bench for pc_call_stack: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_pc_call_stack;
  localparam int ADDR_W = 11;
  localparam int REL_W  = 10;
  localparam int DEPTH  = 4;
  localparam int SP_W   = $clog2(DEPTH + 1);
  localparam int MASK   = (1 << ADDR_W) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0, enable = 1'b0, preload = 1'b0;
  logic [ADDR_W-1:0] preload_addr = '0;
  logic [REL_W-1:0]  rel = '0;
  logic              jsr = 1'b0, ret = 1'b0, jmp = 1'b0, clear_err = 1'b0;
  logic [ADDR_W-1:0] pc, incr_pc, stack_top;
  logic [SP_W-1:0]   sp;
  logic              full, empty, overflow, underflow;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_pc = 0;
  int m_stk[$];
  bit m_ovf = 0, m_unf = 0;

  pc_call_stack #(.ADDR_W(ADDR_W), .REL_W(REL_W), .DEPTH(DEPTH)) dut (
    .clock_i(clock), .reset_i(reset), .enable_i(enable), .preload_i(preload),
    .preload_addr_i(preload_addr), .relative_addr_i(rel), .jsr_i(jsr),
    .ret_i(ret), .jmp_i(jmp), .clear_err_i(clear_err), .pc_o(pc),
    .incr_pc_o(incr_pc), .sp_o(sp), .stack_top_o(stack_top), .full_o(full),
    .empty_o(empty), .overflow_o(overflow), .underflow_o(underflow)
  );

  always #5 clock = ~clock;

  task automatic model_step();
    int off;
    bit nov, nun;
    off = int'(rel);
    if (rel[REL_W-1]) off -= (1 << REL_W);
    nov = 0; nun = 0;
    if (reset) begin
      m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      if (enable) begin
        if (jsr) begin
          if (m_stk.size() < DEPTH) begin m_stk.push_back(m_pc); m_pc = m_pc + off + 1; end
          else begin m_pc = m_pc + 1; nov = 1; end
        end else if (ret) begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back() + 1;
          else begin m_pc = m_pc + 1; nun = 1; end
        end else if (jmp) m_pc = m_pc + off + 1;
        else if (preload) m_pc = int'(preload_addr);
        else m_pc = m_pc + 1;
        m_pc = m_pc & MASK;
      end
      m_ovf = nov | (m_ovf & !clear_err);
      m_unf = nun | (m_unf & !clear_err);
    end
  endtask

  // one clock edge; inputs are stable around the edge, outputs sampled 1ns later
  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    enable = 1'b1; preload = 0; jsr = 0; ret = 0; jmp = 0; clear_err = 0; reset = 0;
    rel = '0; preload_addr = '0;
  endtask

  task automatic go_to(input int a);
    idle_inputs(); preload = 1; preload_addr = ADDR_W'(a); cyc(); idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1; cyc(); reset = 0;
    total++;
    if (pc !== 0 || incr_pc !== 1 || sp !== 0 || stack_top !== 0 || empty !== 1 ||
        full !== 0 || overflow !== 0 || underflow !== 0) begin
      bad++;
      $display("FAIL reset: pc=%0d incr=%0d sp=%0d top=%0d e=%b f=%b o=%b u=%b want 0 1 0 0 1 0 0 0",
               pc, incr_pc, sp, stack_top, empty, full, overflow, underflow);
    end
  endtask

  task automatic test_idle();
    for (int i = 1; i <= 3; i++) begin
      cyc(); total++;
      if (pc !== ADDR_W'(i) || incr_pc !== ADDR_W'(i + 1) || empty !== 1 || overflow !== 0 || underflow !== 0) begin
        bad++;
        $display("FAIL idle%0d: pc=%0d incr=%0d empty=%b want pc=%0d incr=%0d empty=1", i, pc, incr_pc, empty, i, i + 1);
      end
    end
  endtask

  task automatic test_call_ret();
    go_to(5);
    jsr = 1; rel = 10'd10; cyc(); idle_inputs(); total++;
    if (pc !== 16 || sp !== 1 || stack_top !== 5 || incr_pc !== 17) begin
      bad++; $display("FAIL jsr: pc=%0d sp=%0d top=%0d incr=%0d want 16 1 5 17", pc, sp, stack_top, incr_pc);
    end
    ret = 1; cyc(); idle_inputs(); total++;
    if (pc !== 6 || sp !== 0 || empty !== 1 || stack_top !== 0) begin
      bad++; $display("FAIL ret: pc=%0d sp=%0d empty=%b top=%0d want 6 0 1 0", pc, sp, empty, stack_top);
    end
  endtask

  task automatic test_overflow();
    idle_inputs(); reset = 1; cyc(); idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      jsr = 1; rel = '0; cyc(); total++;
      if (pc !== ADDR_W'(k) || sp !== SP_W'(k) || stack_top !== ADDR_W'(k - 1) || full !== (k == 4)) begin
        bad++; $display("FAIL push%0d: pc=%0d sp=%0d top=%0d full=%b want %0d %0d %0d %0b",
                        k, pc, sp, stack_top, full, k, k, k - 1, k == 4);
      end
    end
    cyc(); idle_inputs(); total++;
    if (pc !== 5 || sp !== 4 || overflow !== 1 || stack_top !== 3) begin
      bad++; $display("FAIL overflow: pc=%0d sp=%0d ovf=%b top=%0d want 5 4 1 3", pc, sp, overflow, stack_top);
    end
    for (int k = 4; k >= 1; k--) begin
      ret = 1; cyc(); total++;
      if (pc !== ADDR_W'(k) || sp !== SP_W'(k - 1)) begin
        bad++; $display("FAIL pop: pc=%0d sp=%0d want %0d %0d", pc, sp, k, k - 1);
      end
    end
    idle_inputs(); clear_err = 1; cyc(); idle_inputs(); total++;
    if (overflow !== 0 || underflow !== 0) begin
      bad++; $display("FAIL ovf_clear: ovf=%b unf=%b want 0 0", overflow, underflow);
    end
  endtask

  task automatic test_underflow();
    go_to(7);
    ret = 1; cyc(); idle_inputs(); total++;
    if (pc !== 8 || underflow !== 1 || sp !== 0) begin
      bad++; $display("FAIL underflow: pc=%0d unf=%b sp=%0d want 8 1 0", pc, underflow, sp);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); total++;
      if (underflow !== 1) begin bad++; $display("FAIL unf_hold: unf=%b want 1", underflow); end
    end
    clear_err = 1; cyc(); total++;
    if (underflow !== 0) begin bad++; $display("FAIL unf_clear: unf=%b want 0", underflow); end
    // clear and a new error in the same cycle: set wins
    ret = 1; cyc(); idle_inputs(); total++;
    if (underflow !== 1) begin bad++; $display("FAIL set_wins: unf=%b want 1", underflow); end
    // clear works while stalled
    enable = 0; clear_err = 1; cyc(); idle_inputs(); total++;
    if (underflow !== 0) begin bad++; $display("FAIL stall_clear: unf=%b want 0", underflow); end
  endtask

  task automatic test_wrap();
    go_to(2);
    jmp = 1; rel = 10'h3FC; cyc(); idle_inputs(); total++;
    if (pc !== 2047 || incr_pc !== 0 || sp !== 0) begin
      bad++; $display("FAIL wrap_jmp: pc=%0d incr=%0d sp=%0d want 2047 0 0", pc, incr_pc, sp);
    end
    cyc(); total++;
    if (pc !== 0 || incr_pc !== 1) begin
      bad++; $display("FAIL wrap_idle: pc=%0d incr=%0d want 0 1", pc, incr_pc);
    end
  endtask

  task automatic test_priority_stall();
    go_to(20);
    jsr = 1; ret = 1; preload = 1; preload_addr = 11'd100; rel = 10'd3; cyc(); idle_inputs(); total++;
    if (pc !== 24 || sp !== 1 || stack_top !== 20) begin
      bad++; $display("FAIL priority: pc=%0d sp=%0d top=%0d want 24 1 20", pc, sp, stack_top);
    end
    enable = 0; jsr = 1; rel = 10'd3;
    for (int i = 0; i < 2; i++) begin
      cyc(); total++;
      if (pc !== 24 || sp !== 1 || incr_pc !== 25 || stack_top !== 20) begin
        bad++; $display("FAIL stall: pc=%0d sp=%0d incr=%0d top=%0d want 24 1 25 20", pc, sp, incr_pc, stack_top);
      end
    end
    reset = 1; cyc(); idle_inputs(); total++;
    if (pc !== 0 || sp !== 0 || stack_top !== 0) begin
      bad++; $display("FAIL stall_reset: pc=%0d sp=%0d top=%0d want 0 0 0", pc, sp, stack_top);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 99) < 2);
      enable    = ($urandom_range(0, 99) < 85);
      jsr       = ($urandom_range(0, 99) < 30);
      ret       = ($urandom_range(0, 99) < 30);
      jmp       = ($urandom_range(0, 99) < 15);
      preload   = ($urandom_range(0, 99) < 15);
      clear_err = ($urandom_range(0, 99) < 10);
      rel          = REL_W'($urandom);
      preload_addr = ADDR_W'($urandom);
      cyc(); total++;
      if (pc !== ADDR_W'(m_pc) || incr_pc !== ADDR_W'(m_pc + 1) || sp !== SP_W'(m_stk.size()) ||
          stack_top !== ADDR_W'(m_stk.size() ? m_stk[$] : 0) || full !== (m_stk.size() == DEPTH) ||
          empty !== (m_stk.size() == 0) || overflow !== m_ovf || underflow !== m_unf) begin
        bad++;
        $display("FAIL random%0d: pc=%0d sp=%0d top=%0d o=%b u=%b want pc=%0d sp=%0d top=%0d o=%b u=%b",
                 n, pc, sp, stack_top, overflow, underflow, m_pc, m_stk.size(),
                 m_stk.size() ? m_stk[$] : 0, m_ovf, m_unf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2;
    test_reset();
    test_idle();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_wrap();
    test_priority_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
- Parametrised program-counter unit with a hardware return-address stack.
- Generalises the fixed 11-bit / 4-deep PC: configurable address width, offset width and stack depth.
- Adds signed relative branches, a plain relative jump, a stall input, full/empty status and sticky overflow/underflow error flags.
- Sits at the front of the instruction-fetch path; its `pc` output drives the program-memory address.

Parameters:
- ADDR_W, 11: width of pc, preload address and stack entries.
- REL_W, 10: width of relative_addr; always sign-extended to ADDR_W (REL_W < ADDR_W required).
- DEPTH, 4: number of return-address stack entries (>= 1); stack pointer width is clog2(DEPTH+1).

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: 1 = advance this cycle; 0 = hold all state.
- preload, input, 1: load pc from preload_addr.
- preload_addr, input, ADDR_W: absolute target.
- relative_addr, input, REL_W: signed offset for jsr/jmp.
- jsr, input, 1: call (push and branch relative).
- ret, input, 1: return (pop and resume).
- jmp, input, 1: relative branch without push.
- clear_err, input, 1: clears sticky error flags.
- pc, output, ADDR_W: current program counter (registered).
- incr_pc, output, ADDR_W: pc+1 modulo 2^ADDR_W (registered).
- sp, output, clog2(DEPTH+1): number of valid stack entries.
- stack_top, output, ADDR_W: entry at sp-1; 0 when empty (registered).
- full, output, 1: sp == DEPTH.
- empty, output, 1: sp == 0.
- overflow, output, 1: sticky; a jsr arrived while full.
- underflow, output, 1: sticky; a ret arrived while empty.

Behaviour:
- All state updates on the rising edge of clock. full and empty decode sp combinationally; all other outputs are registers.
- Reset values (sync, highest priority):
  - pc = 0, incr_pc = 1, sp = 0, stack_top = 0.
  - overflow = 0, underflow = 0.
  - all stack entries = 0.
  - Reset mid-call discards the stack.
- enable = 0: pc, sp, stack and flags hold; the command inputs are ignored.
  - Exception: clear_err still clears the flags.
- Next-pc priority when enabled, one command only per cycle: jsr > ret > jmp > preload > increment.
- Arithmetic: off = sign-extend(relative_addr) to ADDR_W. All sums are modulo 2^ADDR_W, so wrap-around is silent.
- jsr, not full:
  - stack[sp] <= pc; sp <= sp+1.
  - pc <= pc + off + 1.
- jsr, full:
  - no push; sp is unchanged.
  - pc <= pc + 1; overflow <= 1.
- ret, not empty:
  - pc <= stack[sp-1] + 1; sp <= sp-1.
- ret, empty:
  - pc <= pc + 1; underflow <= 1.
- jmp: pc <= pc + off + 1; stack unchanged.
- preload: pc <= preload_addr; stack unchanged.
- No command: pc <= pc + 1.
- Latency and visibility:
  - New pc is visible 1 cycle after the command edge.
  - incr_pc always equals new pc + 1 in the same cycle.
  - stack_top reflects the post-update sp in the same cycle as pc.
- Flags:
  - Set on the error edge; remain set until reset or clear_err = 1.
  - If clear_err and a new error occur in the same cycle, set wins.
- Simultaneous jsr and ret: jsr wins; ret is ignored that cycle (no pop).
- Popped entries are not cleared; only stack_top/sp visibility changes.

Test Plan:
- Reset then 3 idle enabled cycles -> pc = 1, 2, 3; incr_pc = 2, 3, 4; empty = 1; flags 0.
- At pc = 5, jsr with rel = 10 -> pc = 16, sp = 1, stack_top = 5. Then ret -> pc = 6, sp = 0, empty = 1.
- With DEPTH = 4, five consecutive jsr starting at pc = 0, rel = 0:
  - pushes 0, 1, 2, 3; pc reaches 4 with full = 1.
  - 5th jsr: pc = 5, sp stays 4, overflow = 1.
  - 4 rets then return 4, 3, 2, 1.
- ret when empty at pc = 7 -> pc = 8, underflow = 1. Flag holds for 3 cycles; clear_err -> 0.
- Negative offset and wrap, ADDR_W = 11:
  - pc = 2, jmp with rel = 10'h3FC (-4) -> pc = 2047 (wrap), incr_pc = 0, sp unchanged.
  - Next idle cycle -> pc = 0.
- Priority and stall:
  - jsr + ret + preload (addr 100) together at pc = 20, rel = 3 -> pc = 24, push 20.
  - enable = 0 with jsr held 2 cycles -> pc stays 24, sp unchanged.
  - reset during stall -> pc = 0, sp = 0.
